// File: rtl/la_capture_core.sv
// la_capture_core - logic-analyzer capture engine.
// Samples a DATA_W-bit probe bus into a DEPTH-entry circular buffer with a
// programmable pre-trigger window, masked level/edge triggers and an external
// trigger. Readout is linearised so address 0 is the oldest stored sample.
// Optional build macro: LA_STORAGE_QUALIFY_EN adds input qual_i; only cycles
// with qual_i=1 are stored, counted and evaluated for triggers.
module la_capture_core #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef LA_STORAGE_QUALIFY_EN
  input  logic              qual_i,
`endif
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  // Masked compare: a bit with mask=0 never blocks the match.
  function automatic logic masked_match(input logic [DATA_W-1:0] d,
                                        input logic [DATA_W-1:0] v,
                                        input logic [DATA_W-1:0] m);
    return &(~(d ^ v) | ~m);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   pretrig_q, pretrig_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                match_q, match_d;
  logic                triggered_q, triggered_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                qual_s;
  logic                match_s;
  logic                rise_s;
  logic                fall_s;
  logic                trig_hit_s;
  logic                arm_ok_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   post_len_s;
  logic [ADDR_W-1:0]   rd_idx_s;

`ifdef LA_STORAGE_QUALIFY_EN
  assign qual_s = qual_i;
`else
  assign qual_s = 1'b1;
`endif

  assign match_s    = masked_match(data_i, val_q, mask_q);
  assign rise_s     = match_s & ~match_q;
  assign fall_s     = ~match_s & match_q;
  // Samples still owed after the trigger sample so the buffer holds DEPTH in total.
  assign post_len_s = LAST_A - pretrig_q;
  assign arm_ok_s   = arm_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign rd_idx_s   = start_q + rd_addr_i;

  // Trigger condition selected by the mode latched at arm time.
  always_comb begin
    trig_hit_s = 1'b0;
    case (mode_q)
      2'd0:    trig_hit_s = match_s;
      2'd1:    trig_hit_s = rise_s;
      2'd2:    trig_hit_s = fall_s;
      2'd3:    trig_hit_s = trig_i;
      default: trig_hit_s = 1'b0;
    endcase
  end

  // Next-state, buffer write control and status computation.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    pretrig_d   = pretrig_q;
    mode_d      = mode_q;
    val_d       = val_q;
    mask_d      = mask_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    wr_en_s     = 1'b0;
    // Edge history only advances on stored samples.
    match_d     = qual_s ? match_s : match_q;

    if (abort_i) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else if (arm_ok_s) begin
      // An ADDR_W-wide pretrig cannot exceed DEPTH-1, so the clamp is implicit.
      pretrig_d   = pretrig_i;
      mode_d      = trig_mode_i;
      val_d       = trig_val_i;
      mask_d      = trig_mask_i;
      cnt_d       = {ADDR_W{1'b0}};
      match_d     = 1'b0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      state_d     = (pretrig_i == {ADDR_W{1'b0}}) ? ST_WAIT : ST_PRE;
    end else begin
      case (state_q)
        ST_PRE: begin
          if (qual_s) begin
            wr_en_s = 1'b1;
            wptr_d  = wptr_q + ONE_A;
            if ((cnt_q + ONE_A) == pretrig_q) begin
              state_d = ST_WAIT;
              cnt_d   = {ADDR_W{1'b0}};
            end else begin
              cnt_d = cnt_q + ONE_A;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
        ST_WAIT: begin
          if (qual_s) begin
            wr_en_s = 1'b1;
            wptr_d  = wptr_q + ONE_A;
            if (trig_hit_s) begin
              start_d     = wptr_q - pretrig_q;
              triggered_d = 1'b1;
              if (post_len_s == {ADDR_W{1'b0}}) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_POST;
                cnt_d   = post_len_s;
              end
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
        ST_POST: begin
          if (qual_s) begin
            wr_en_s = 1'b1;
            wptr_d  = wptr_q + ONE_A;
            cnt_d   = cnt_q - ONE_A;
            if (cnt_q == ONE_A) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
        default: begin
          // IDLE and DONE hold with the buffer frozen.
          state_d = state_q;
        end
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wptr_q      <= {ADDR_W{1'b0}};
      cnt_q       <= {ADDR_W{1'b0}};
      start_q     <= {ADDR_W{1'b0}};
      pretrig_q   <= {ADDR_W{1'b0}};
      mode_q      <= 2'd0;
      val_q       <= {DATA_W{1'b0}};
      mask_q      <= {DATA_W{1'b0}};
      match_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      pretrig_q   <= pretrig_d;
      mode_q      <= mode_d;
      val_q       <= val_d;
      mask_q      <= mask_d;
      match_q     <= match_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  // Sample buffer write port; contents are not reset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem[wptr_q] <= data_i;
    end
  end

  // Registered read port, rotated so index 0 is the oldest sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= mem[rd_idx_s];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core - self-checking bench for la_capture_core (DEPTH=16, DATA_W=9).
// A sample-sequence reference model predicts state, flags and buffer contents.
module tb_la_capture_core;
  localparam int DW    = 9;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig = 1'b0;
  logic          qual = 1'b1;
  logic [AW-1:0] pretrig = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    trig_mode = '0;
  logic [DW-1:0] trig_val = '0;
  logic [DW-1:0] trig_mask = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] rd_data;
  logic [2:0]    state;
  logic          triggered;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  la_capture_core #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .arm_i       (arm),
    .abort_i     (abort),
    .pretrig_i   (pretrig),
    .trig_mode_i (trig_mode),
    .trig_val_i  (trig_val),
    .trig_mask_i (trig_mask),
    .trig_i      (trig),
    .data_i      (data),
`ifdef LA_STORAGE_QUALIFY_EN
    .qual_i      (qual),
`endif
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .state_o     (state),
    .triggered_o (triggered),
    .done_o      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gen(input int pat, input int k, input logic [DW-1:0] v);
    logic [DW-1:0] d;
    logic [7:0]    lo;
    lo = 8'(k);
    case (pat)
      0:       d = DW'(k);
      1:       d = {((k <= 2) || (k >= 10)) ? 1'b1 : 1'b0, lo};
      2:       d = (k < 7) ? v : ~v;
      default: d = DW'($urandom_range(0, 7));
    endcase
    return d;
  endfunction

  // Reads one linearised buffer entry (starts and ends at a falling edge).
  task automatic read_at(input int idx, output logic [DW-1:0] v);
    rd_addr = AW'(idx);
    @(posedge clk); #1;
    v = rd_data;
    @(negedge clk);
  endtask

  // Full capture: arm, run to DONE against the model, hold in DONE, read back.
  task automatic capture(input int pre, input int mode, input int val, input int mask,
                         input int pat, input int qmode);
    logic [DW-1:0] seq[$];
    logic [DW-1:0] v, msk, d, rv;
    int  tidx, k, n;
    bit  mprev, m, cond, tr, q, exp_trig, exp_done;
    int  exp_state;
    v = DW'(val);
    msk = DW'(mask);
    tidx = -1; mprev = 1'b0; exp_trig = 1'b0; exp_done = 1'b0;
    arm = 1'b1; pretrig = AW'(pre); trig_mode = 2'(mode);
    trig_val = v; trig_mask = msk; trig = 1'b0; data = DW'($urandom);
    @(posedge clk); #1;
    check("arm_state", state, (pre == 0) ? 2 : 1);
    check("arm_trig", triggered, 0);
    check("arm_done", done, 0);
    @(negedge clk);
    arm = 1'b0;
    // Config must be held internally, so scramble the inputs.
    pretrig = AW'($urandom); trig_mode = 2'($urandom);
    trig_val = DW'($urandom); trig_mask = DW'($urandom);
    k = 0;
    while (!exp_done && k < 300) begin
      d  = gen(pat, k, v);
      tr = ($urandom_range(0, 7) == 0);
      q  = (qmode == 0) ? 1'b1 : (qmode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
`ifndef LA_STORAGE_QUALIFY_EN
      q  = 1'b1;
`endif
      data = d; trig = tr; qual = q;
      if (q) begin
        n = seq.size();
        m = (((d ^ v) & msk) == '0);
        case (mode)
          0:       cond = m;
          1:       cond = m & ~mprev;
          2:       cond = ~m & mprev;
          default: cond = tr;
        endcase
        if (n >= pre && tidx < 0 && cond) tidx = n;
        mprev = m;
        seq.push_back(d);
      end
      exp_trig  = (tidx >= 0);
      exp_done  = exp_trig && (seq.size() == tidx - pre + DEPTH);
      exp_state = exp_done ? 4 : exp_trig ? 3 : (seq.size() < pre) ? 1 : 2;
      @(posedge clk); #1;
      check("run_state", state, exp_state);
      check("run_trig", triggered, exp_trig);
      check("run_done", done, exp_done);
      @(negedge clk);
      k++;
    end
    qual = 1'b1;
    if (!exp_done) begin
      check("capture_timeout", 0, 1);
    end else begin
      for (int i = 0; i < 3; i++) begin
        trig = 1'b1; data = DW'($urandom);
        @(posedge clk); #1;
        check("done_hold_state", state, 4);
        check("done_hold_trig", triggered, 1);
        check("done_hold_done", done, 1);
        @(negedge clk);
      end
      trig = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        read_at(i, rv);
        check("readout", rv, seq[tidx - pre + i]);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] rv;
    // Reset state
    #12;
    check("rst_state", state, 0);
    check("rst_trig", triggered, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_hold", state, 0);
    @(negedge clk);

    // Level match on counting data, pretrig 0
    capture(0, 0, 9'h005, 9'h1FF, 0, 0);
    read_at(0, rv);  check("t1_idx0", rv, 9'd5);
    read_at(15, rv); check("t1_idx15", rv, 9'd20);

    // Rising match with pre-trigger matches ignored
    capture(4, 1, 9'h100, 9'h100, 1, 0);
    read_at(4, rv); check("t2_idx4", rv, 9'h10A);
    read_at(0, rv); check("t2_idx0", rv, 9'h006);

    // Falling match on an already-matching bus
    capture(3, 2, 9'h0A5, 9'h1FF, 2, 0);
    read_at(3, rv); check("t3_idx3", rv, 9'h15A);

    // External trigger, then pretrig = DEPTH-1 boundary
    capture(5, 3, 0, 0, 3, 0);
    capture(15, 0, 9'd20, 9'h1FF, 0, 0);

    // Arm ignored in POST; abort wins over simultaneous arm
    arm = 1'b1; pretrig = '0; trig_mode = 2'd0; trig_val = 9'd3; trig_mask = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data = DW'(k);
      @(posedge clk);
      @(negedge clk);
    end
    check("ab_in_post", state, 3);
    arm = 1'b1;
    @(posedge clk); #1;
    check("arm_ignored", state, 3);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_state", state, 0);
    check("abort_trig", triggered, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    abort = 1'b0; arm = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", state, 0);
    @(negedge clk);

    // Asynchronous reset during WAIT
    arm = 1'b1; trig_val = 9'h1FF; trig_mask = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    arm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data = DW'(k);
      @(posedge clk);
      @(negedge clk);
    end
    check("rw_wait", state, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_trig", triggered, 0);
    check("arst_done", done, 0);
    check("arst_rdata", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", state, 0);
    @(negedge clk);

    // Qualified storage (every third cycle) then randomized captures
    capture(2, 0, 3, 7, 3, 1);
    for (int r = 0; r < 6; r++) begin
      capture($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7),
              $urandom_range(1, 7), 3, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised logic-analyzer capture engine: samples a DATA_W-bit probe bus into a DEPTH-entry circular buffer on the probed clock.
- Adds a programmable pre-trigger window, masked value/edge trigger modes and an external trigger input.
- Provides a linearised readout port (address 0 = oldest sample).
- Sits under the analyzer top, between the JTAG control bridge (arm/config/readout) and the probed signals.

Parameters:
DATA_W, 9, probe bus width (1..256)
DEPTH, 1024, sample buffer depth; power of two, >= 4
ADDR_W, $clog2(DEPTH), buffer address width (derived; do not override)

Ports:
clk_i  input  1  probed sample clock
rst_n_i  input  1  asynchronous active-low reset
arm_i  input  1  single-cycle pulse; start capture
abort_i  input  1  single-cycle pulse; return to IDLE
pretrig_i  input  ADDR_W  samples kept before the trigger; sampled on arm
trig_mode_i  input  2  0=level match, 1=rising match, 2=falling match, 3=external trig_i; sampled on arm
trig_val_i  input  DATA_W  compare value; sampled on arm
trig_mask_i  input  DATA_W  1 = bit participates in compare; sampled on arm
trig_i  input  1  external trigger, level-sensitive
data_i  input  DATA_W  probe bus
rd_addr_i  input  ADDR_W  readout index, 0 = oldest sample
rd_data_o  output  DATA_W  readout data, 1-cycle latency
state_o  output  3  0=IDLE, 1=PRE, 2=WAIT, 3=POST, 4=DONE
triggered_o  output  1  high from the trigger sample until the next arm/abort
done_o  output  1  high in DONE

Behaviour:
- Reset: state IDLE; write pointer, counters, match history and start pointer = 0; triggered_o=0, done_o=0, rd_data_o=0. Buffer contents undefined.
- match = &(~(data_i ^ trig_val) | ~trig_mask). The all-zero mask always matches.
- match_r holds the previous cycle's match and is cleared on arm.
- rise = match & ~match_r; fall = ~match & match_r.
- Mode 3 uses trig_i directly.
- arm_i is accepted only in IDLE or DONE.
  - On accept: latch config; clamp pretrig to DEPTH-1; clear counters and triggered_o; go to PRE, or to WAIT if pretrig=0.
  - arm_i in any other state is ignored.
- Write rule: every cycle in PRE/WAIT/POST, write data_i at wptr, then wptr += 1 modulo DEPTH (wraps silently).
- PRE: write until pretrig samples are stored, then go to WAIT. Triggers during PRE are ignored.
- WAIT:
  - Writes continue circularly.
  - First cycle with a trigger condition: that sample is written at wptr; record start = wptr - pretrig (mod DEPTH); triggered_o=1; go to POST with post count = DEPTH-pretrig-1.
  - If post count = 0 (pretrig = DEPTH-1), go directly to DONE.
- POST: write the remaining count samples, then DONE. Total valid samples = DEPTH; the trigger sample is at readout index pretrig.
- DONE: no writes. done_o=1. Buffer frozen until the next arm.
- abort_i in any state: go to IDLE next cycle, clear triggered_o and done_o. abort wins over a simultaneous arm.
- Readout: rd_data_o <= mem[(start + rd_addr_i) mod DEPTH] every cycle, in any state. Contents are valid only in DONE.
- Memory: single write port and single registered read port (block-RAM inferable). Same-address read/write during capture returns old data.
- Reset mid-capture: immediate return to the reset state; no partial done.

Optional Feature:
- Macro: LA_STORAGE_QUALIFY_EN.
- With the macro: extra input qual_i (1 bit).
  - Writes, wptr advance, PRE/POST counting and trigger evaluation happen only on cycles where qual_i=1.
  - match_r updates only on qualified cycles, so edges are between qualified samples.
  - Typical use: qual_i driven by the data-valid strobe, so idle-bus cycles are not stored.
- Without the macro: qual_i does not exist; every cycle is qualified.

Test Plan:
- DEPTH=16, pretrig=0, mode 0, val=0x005, mask=0x1FF, data_i counting 0,1,2… after arm -> trigger at data 5; DONE after 15 more cycles; readout 0..15 = 5..20; triggered_o rises the cycle after data 5 is sampled.
- DEPTH=16, pretrig=4, mode 1, mask=0x100, data_i bit8 forced high for cycles 0–2 then low until cycle 10, then high -> cycle-0..2 matches ignored (PRE); trigger at cycle 10; readout idx 4 = cycle-10 sample, idx 0 = cycle-6 sample.
- Mode 2 on an already-matching bus at arm, then mismatch at cycle 7 -> trigger at cycle 7 (match_r cleared on arm so no false fall at cycle 0); readout idx pretrig = cycle-7 sample.
- Mode 3, trig_i pulsed during POST and during DONE -> no re-trigger; arm in DONE restarts, done_o drops next cycle.
- abort_i during POST, simultaneously with arm_i -> IDLE, done_o=0, triggered_o=0; rst_n_i low during WAIT -> all outputs 0 asynchronously.
- LA_STORAGE_QUALIFY_EN, qual_i=1 every third cycle, pretrig=2 -> buffer holds only qualified samples; DONE after DEPTH qualified samples; readout contiguous with no gaps.
